// File: rtl/axi_buffered_adapter_pkg.sv
// axi_buffered_adapter_pkg: shared AXI4 field widths and response codes for the buffered adapter
package axi_buffered_adapter_pkg;
    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int QOS_W    = 4;
    localparam int REGION_W = 4;
    localparam int RESP_W   = 2;
    // AW/AR fields other than id, addr and user (lock is one bit)
    localparam int AX_W = LEN_W + SIZE_W + BURST_W + 1 + CACHE_W + PROT_W + QOS_W + REGION_W;
    typedef enum logic [RESP_W-1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;
endpackage

// File: rtl/axi_buffered_fifo.sv
// axi_buffered_fifo: registered-output valid/ready FIFO; ready depends only on the stored count
module axi_buffered_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [CW-1:0]    cnt;
    logic             push, pop;
    assign in_ready  = cnt < CW'(DEPTH);
    assign out_valid = cnt != '0;
    assign out_data  = mem[rp];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // storage, pointers and occupancy; storage cleared so payload outputs read zero after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= in_data;
                wp      <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/axi_buffered_adapter.sv
// axi_buffered_adapter: per-channel AXI4 FIFOs with write/read outstanding limiters; AXI_BUFFERED_ADAPTER_USER_EN forwards user fields
module axi_buffered_adapter
    import axi_buffered_adapter_pkg::*;
#(
    parameter int ID_WIDTH           = 4,
    parameter int ADDR_WIDTH         = 64,
    parameter int DATA_WIDTH         = 64,
    parameter int USER_WIDTH         = 1,
    parameter int DEPTH              = 2,
    parameter int MAX_WR_OUTSTANDING = 8,
    parameter int MAX_RD_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [LEN_W-1:0]        s_axi_awlen,
    input  logic [SIZE_W-1:0]       s_axi_awsize,
    input  logic [BURST_W-1:0]      s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [CACHE_W-1:0]      s_axi_awcache,
    input  logic [PROT_W-1:0]       s_axi_awprot,
    input  logic [QOS_W-1:0]        s_axi_awqos,
    input  logic [REGION_W-1:0]     s_axi_awregion,
    input  logic [USER_WIDTH-1:0]   s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [USER_WIDTH-1:0]   s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [RESP_W-1:0]       s_axi_bresp,
    output logic [USER_WIDTH-1:0]   s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [LEN_W-1:0]        s_axi_arlen,
    input  logic [SIZE_W-1:0]       s_axi_arsize,
    input  logic [BURST_W-1:0]      s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [CACHE_W-1:0]      s_axi_arcache,
    input  logic [PROT_W-1:0]       s_axi_arprot,
    input  logic [QOS_W-1:0]        s_axi_arqos,
    input  logic [REGION_W-1:0]     s_axi_arregion,
    input  logic [USER_WIDTH-1:0]   s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_W-1:0]       s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [USER_WIDTH-1:0]   s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [LEN_W-1:0]        m_axi_awlen,
    output logic [SIZE_W-1:0]       m_axi_awsize,
    output logic [BURST_W-1:0]      m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [CACHE_W-1:0]      m_axi_awcache,
    output logic [PROT_W-1:0]       m_axi_awprot,
    output logic [QOS_W-1:0]        m_axi_awqos,
    output logic [REGION_W-1:0]     m_axi_awregion,
    output logic [USER_WIDTH-1:0]   m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic [USER_WIDTH-1:0]   m_axi_wuser,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [RESP_W-1:0]       m_axi_bresp,
    input  logic [USER_WIDTH-1:0]   m_axi_buser,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [LEN_W-1:0]        m_axi_arlen,
    output logic [SIZE_W-1:0]       m_axi_arsize,
    output logic [BURST_W-1:0]      m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [CACHE_W-1:0]      m_axi_arcache,
    output logic [PROT_W-1:0]       m_axi_arprot,
    output logic [QOS_W-1:0]        m_axi_arqos,
    output logic [REGION_W-1:0]     m_axi_arregion,
    output logic [USER_WIDTH-1:0]   m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [RESP_W-1:0]       m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [USER_WIDTH-1:0]   m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
`ifdef AXI_BUFFERED_ADAPTER_USER_EN
    localparam int UW = USER_WIDTH;
`else
    localparam int UW = 0;
`endif
    localparam int AXW = ID_WIDTH + ADDR_WIDTH + AX_W;
    localparam int WW  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam int BW  = ID_WIDTH + RESP_W;
    localparam int RW  = ID_WIDTH + DATA_WIDTH + RESP_W + 1;
    localparam int WCW = $clog2(MAX_WR_OUTSTANDING + 1);
    localparam int RCW = $clog2(MAX_RD_OUTSTANDING + 1);

    logic [AXW+UW-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [WW+UW-1:0]  w_in, w_out;
    logic [BW+UW-1:0]  b_in, b_out;
    logic [RW+UW-1:0]  r_in, r_out;
    logic              aw_fifo_ready, ar_fifo_ready, wr_ok, rd_ok;
    logic [WCW-1:0]    wr_cnt;
    logic [RCW-1:0]    rd_cnt;
    logic              aw_hs, b_hs, ar_hs, rlast_hs;

    assign aw_in[AXW-1:0] = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                             s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion};
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion} = aw_out[AXW-1:0];
    assign ar_in[AXW-1:0] = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion} = ar_out[AXW-1:0];
    assign w_in[WW-1:0] = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out[WW-1:0];
    assign b_in[BW-1:0] = {m_axi_bid, m_axi_bresp};
    assign {s_axi_bid, s_axi_bresp} = b_out[BW-1:0];
    assign r_in[RW-1:0] = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out[RW-1:0];

`ifdef AXI_BUFFERED_ADAPTER_USER_EN
    assign aw_in[AXW+:UW] = s_axi_awuser;
    assign m_axi_awuser   = aw_out[AXW+:UW];
    assign ar_in[AXW+:UW] = s_axi_aruser;
    assign m_axi_aruser   = ar_out[AXW+:UW];
    assign w_in[WW+:UW]   = s_axi_wuser;
    assign m_axi_wuser    = w_out[WW+:UW];
    assign b_in[BW+:UW]   = m_axi_buser;
    assign s_axi_buser    = b_out[BW+:UW];
    assign r_in[RW+:UW]   = m_axi_ruser;
    assign s_axi_ruser    = r_out[RW+:UW];
`else
    logic unused_user;
    assign unused_user  = ^{s_axi_awuser, s_axi_aruser, s_axi_wuser, m_axi_buser, m_axi_ruser};
    assign m_axi_awuser = '0;
    assign m_axi_aruser = '0;
    assign m_axi_wuser  = '0;
    assign s_axi_buser  = '0;
    assign s_axi_ruser  = '0;
`endif

    assign wr_ok         = wr_cnt < WCW'(MAX_WR_OUTSTANDING);
    assign rd_ok         = rd_cnt < RCW'(MAX_RD_OUTSTANDING);
    assign s_axi_awready = aw_fifo_ready && wr_ok;
    assign s_axi_arready = ar_fifo_ready && rd_ok;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign b_hs          = s_axi_bvalid && s_axi_bready;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign rlast_hs      = s_axi_rvalid && s_axi_rready && s_axi_rlast;

    // outstanding-burst counters; a stray completion at zero is ignored rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= wr_cnt + WCW'(aw_hs) - WCW'(b_hs && wr_cnt != '0);
            rd_cnt <= rd_cnt + RCW'(ar_hs) - RCW'(rlast_hs && rd_cnt != '0);
        end
    end

    wr_underflow: assert property (@(posedge clk) disable iff (rst) b_hs |-> wr_cnt != '0);
    rd_underflow: assert property (@(posedge clk) disable iff (rst) rlast_hs |-> rd_cnt != '0);

    axi_buffered_fifo #(.WIDTH(AXW + UW), .DEPTH(DEPTH)) u_aw (
        .clk(clk), .rst(rst), .in_data(aw_in), .in_valid(s_axi_awvalid && wr_ok), .in_ready(aw_fifo_ready),
        .out_data(aw_out), .out_valid(m_axi_awvalid), .out_ready(m_axi_awready));
    axi_buffered_fifo #(.WIDTH(WW + UW), .DEPTH(DEPTH)) u_w (
        .clk(clk), .rst(rst), .in_data(w_in), .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
        .out_data(w_out), .out_valid(m_axi_wvalid), .out_ready(m_axi_wready));
    axi_buffered_fifo #(.WIDTH(BW + UW), .DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in), .in_valid(m_axi_bvalid), .in_ready(m_axi_bready),
        .out_data(b_out), .out_valid(s_axi_bvalid), .out_ready(s_axi_bready));
    axi_buffered_fifo #(.WIDTH(AXW + UW), .DEPTH(DEPTH)) u_ar (
        .clk(clk), .rst(rst), .in_data(ar_in), .in_valid(s_axi_arvalid && rd_ok), .in_ready(ar_fifo_ready),
        .out_data(ar_out), .out_valid(m_axi_arvalid), .out_ready(m_axi_arready));
    axi_buffered_fifo #(.WIDTH(RW + UW), .DEPTH(DEPTH)) u_r (
        .clk(clk), .rst(rst), .in_data(r_in), .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
        .out_data(r_out), .out_valid(s_axi_rvalid), .out_ready(s_axi_rready));
endmodule

// File: tb/tb_axi_buffered_adapter.sv
// tb_axi_buffered_adapter: scoreboard bench for axi_buffered_adapter (DEPTH=4, MAX_WR=2, MAX_RD=1)
module tb_axi_buffered_adapter;
    import axi_buffered_adapter_pkg::*;
    localparam int IW = 4, AW = 32, DW = 32, UW = 1;
`ifdef AXI_BUFFERED_ADAPTER_USER_EN
    localparam logic EXP_USER = 1'b1;
`else
    localparam logic EXP_USER = 1'b0;
`endif
    logic clk = 0, rst = 1;
    logic [IW-1:0] s_axi_awid, s_axi_arid, m_axi_awid, m_axi_arid, s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
    logic [AW-1:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
    logic [7:0] s_axi_awlen, s_axi_arlen, m_axi_awlen, m_axi_arlen;
    logic [2:0] s_axi_awsize, s_axi_arsize, m_axi_awsize, m_axi_arsize, s_axi_awprot, s_axi_arprot, m_axi_awprot, m_axi_arprot;
    logic [1:0] s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
    logic s_axi_awlock, s_axi_arlock, m_axi_awlock, m_axi_arlock;
    logic [3:0] s_axi_awcache, s_axi_arcache, m_axi_awcache, m_axi_arcache, s_axi_awqos, s_axi_arqos, m_axi_awqos, m_axi_arqos;
    logic [3:0] s_axi_awregion, s_axi_arregion, m_axi_awregion, m_axi_arregion;
    logic [UW-1:0] s_axi_awuser, s_axi_aruser, m_axi_awuser, m_axi_aruser, s_axi_wuser, m_axi_wuser;
    logic [UW-1:0] s_axi_buser, m_axi_buser, s_axi_ruser, m_axi_ruser;
    logic s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready, s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
    logic [DW/8-1:0] s_axi_wstrb, m_axi_wstrb;
    logic s_axi_wlast, m_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
    logic [1:0] s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
    logic s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
    logic s_axi_rlast, m_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;
    int passed = 0, total = 0;
    logic [DW+DW/8:0] wq[$];
    logic [IW+DW:0] rq[$];

    axi_buffered_adapter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(4),
                           .MAX_WR_OUTSTANDING(2), .MAX_RD_OUTSTANDING(1)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awqos(s_axi_awqos), .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast), .s_axi_wuser(s_axi_wuser),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
        .s_axi_arqos(s_axi_arqos), .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wuser(m_axi_wuser),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arqos(m_axi_arqos), .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m_axi_wready = 0; m_axi_awready = 0; m_axi_arready = 0;
        s_axi_awvalid = 1; s_axi_awid = 1; s_axi_arvalid = 1; s_axi_arid = 1;
        tick();
        s_axi_awvalid = 0; s_axi_arvalid = 0;
        for (int i = 0; i < 3; i++) begin
            s_axi_wvalid = 1; s_axi_wdata = DW'(i + 1); s_axi_wstrb = '1;
            tick();
        end
        s_axi_wvalid = 0;
        total++; if (m_axi_wvalid !== 1'b1) $display("FAIL pre_reset_wvalid: got %b want 1", m_axi_wvalid); else passed++;
        total++; if (dut.wr_cnt !== 2'd1) $display("FAIL pre_reset_wr_cnt: got %0d want 1", dut.wr_cnt); else passed++;
        #2 rst = 1;
        #1;
        total++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid} !== 5'b0)
            $display("FAIL reset_valids: got %b want 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid}); else passed++;
        total++; if ({s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready} !== 5'b11111)
            $display("FAIL reset_readies: got %b want 11111", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}); else passed++;
        total++; if (m_axi_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", m_axi_wdata); else passed++;
        total++; if (m_axi_awaddr !== '0) $display("FAIL reset_awaddr: got %h want 0", m_axi_awaddr); else passed++;
        total++; if (dut.wr_cnt !== '0 || dut.rd_cnt !== '0)
            $display("FAIL reset_counts: got wr %0d rd %0d want 0 0", dut.wr_cnt, dut.rd_cnt); else passed++;
        tick();
        rst = 0;
        tick();
        total++; if (m_axi_wvalid !== 1'b0) $display("FAIL post_reset_wvalid: got %b want 0", m_axi_wvalid); else passed++;
    endtask

    task automatic test_streaming();
        int n = 0;
        logic [DW+DW/8:0] exp;
        m_axi_wready = 1; m_axi_awready = 1;
        s_axi_awvalid = 1; s_axi_awid = 3; s_axi_awaddr = 32'h1000; s_axi_awlen = 15; s_axi_awsize = 2; s_axi_awburst = 1;
        total++; if (s_axi_awready !== 1'b1) $display("FAIL stream_awready: got %b want 1", s_axi_awready); else passed++;
        tick();
        s_axi_awvalid = 0;
        total++; if (m_axi_awvalid !== 1'b1 || m_axi_awlen !== 8'd15 || m_axi_awaddr !== 32'h1000 || m_axi_awid !== 4'd3)
            $display("FAIL stream_aw: got v%b len %0d addr %h id %0d want v1 len 15 addr 1000 id 3",
                     m_axi_awvalid, m_axi_awlen, m_axi_awaddr, m_axi_awid); else passed++;
        for (int i = 0; i <= 16; i++) begin
            s_axi_wvalid = i < 16; s_axi_wdata = $urandom; s_axi_wstrb = 4'($urandom); s_axi_wlast = i == 15;
            total++; if (m_axi_wvalid !== (i >= 1)) $display("FAIL stream_wvalid_%0d: got %b want %b", i, m_axi_wvalid, i >= 1); else passed++;
            if (m_axi_wvalid && m_axi_wready) begin
                exp = wq.size() ? wq.pop_front() : 'x;
                total++; if ({m_axi_wdata, m_axi_wstrb, m_axi_wlast} !== exp)
                    $display("FAIL stream_beat_%0d: got %h want %h", n, {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, exp); else passed++;
                total++; if (m_axi_wlast !== (n == 15)) $display("FAIL stream_wlast_%0d: got %b want %b", n, m_axi_wlast, n == 15); else passed++;
                n++;
            end
            if (s_axi_wvalid && s_axi_wready) wq.push_back({s_axi_wdata, s_axi_wstrb, s_axi_wlast});
            tick();
        end
        s_axi_wvalid = 0;
        total++; if (n !== 16 || wq.size() !== 0) $display("FAIL stream_count: got %0d beats, %0d left want 16, 0", n, wq.size()); else passed++;
        m_axi_bvalid = 1; m_axi_bid = 3; m_axi_bresp = OKAY; s_axi_bready = 1;
        tick();
        m_axi_bvalid = 0;
        total++; if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'd3 || s_axi_bresp !== OKAY)
            $display("FAIL stream_b: got v%b id %0d resp %0d want v1 id 3 resp 0", s_axi_bvalid, s_axi_bid, s_axi_bresp); else passed++;
        tick();
        s_axi_bready = 0;
        total++; if (s_axi_bvalid !== 1'b0 || dut.wr_cnt !== '0)
            $display("FAIL stream_b_done: got v%b cnt %0d want v0 cnt 0", s_axi_bvalid, dut.wr_cnt); else passed++;
    endtask

    task automatic test_back_pressure();
        int k = 0, acc = 0, got = 0;
        logic m_hs, s_hs;
        logic [IW+DW:0] exp;
        m_axi_arready = 1; s_axi_arvalid = 1; s_axi_arid = 5;
        tick();
        s_axi_arvalid = 0;
        tick();
        s_axi_rready = 0;
        for (int c = 0; c < 8; c++) begin
            m_axi_rvalid = k < 6; m_axi_rid = 5; m_axi_rdata = 32'hA000 + DW'(k); m_axi_rlast = k == 5; m_axi_rresp = OKAY;
            if (m_axi_rvalid && m_axi_rready) begin
                rq.push_back({m_axi_rid, m_axi_rdata, m_axi_rlast});
                k++; acc++;
            end
            tick();
        end
        total++; if (acc !== 4) $display("FAIL bp_accepted: got %0d want 4", acc); else passed++;
        total++; if (m_axi_rready !== 1'b0) $display("FAIL bp_rready_full: got %b want 0", m_axi_rready); else passed++;
        s_axi_rready = 1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            m_axi_rvalid = k < 6; m_axi_rid = 5; m_axi_rdata = 32'hA000 + DW'(k); m_axi_rlast = k == 5;
            m_hs = m_axi_rvalid && m_axi_rready;
            s_hs = s_axi_rvalid && s_axi_rready;
            if (s_hs) begin
                exp = rq.size() ? rq.pop_front() : 'x;
                total++; if ({s_axi_rid, s_axi_rdata, s_axi_rlast} !== exp)
                    $display("FAIL bp_beat_%0d: got %h want %h", got, {s_axi_rid, s_axi_rdata, s_axi_rlast}, exp); else passed++;
                got++;
            end
            if (m_hs) begin
                rq.push_back({m_axi_rid, m_axi_rdata, m_axi_rlast});
                k++;
            end
            tick();
        end
        m_axi_rvalid = 0;
        total++; if (got !== 6) $display("FAIL bp_drained: got %0d want 6", got); else passed++;
        tick();
        total++; if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1)
            $display("FAIL bp_idle: got rvalid %b arready %b want 0 1", s_axi_rvalid, s_axi_arready); else passed++;
    endtask

    task automatic test_write_limiter();
        m_axi_awready = 1; s_axi_bready = 0;
        s_axi_awvalid = 1; s_axi_awid = 1;
        total++; if (s_axi_awready !== 1'b1) $display("FAIL wl_aw1_ready: got %b want 1", s_axi_awready); else passed++;
        tick();
        s_axi_awid = 2;
        total++; if (s_axi_awready !== 1'b1 || m_axi_awid !== 4'd1)
            $display("FAIL wl_aw2: got ready %b m_id %0d want 1 1", s_axi_awready, m_axi_awid); else passed++;
        tick();
        s_axi_awid = 3;
        total++; if (s_axi_awready !== 1'b0 || m_axi_awid !== 4'd2)
            $display("FAIL wl_stall: got ready %b m_id %0d want 0 2", s_axi_awready, m_axi_awid); else passed++;
        m_axi_bvalid = 1; m_axi_bid = 1; m_axi_bresp = OKAY;
        tick();
        m_axi_bid = 2;
        tick();
        m_axi_bvalid = 0;
        total++; if (s_axi_awready !== 1'b0 || s_axi_bvalid !== 1'b1)
            $display("FAIL wl_b_held: got awready %b bvalid %b want 0 1", s_axi_awready, s_axi_bvalid); else passed++;
        s_axi_bready = 1;
        tick();
        total++; if (s_axi_awready !== 1'b1 || s_axi_bid !== 4'd2)
            $display("FAIL wl_restore: got awready %b bid %0d want 1 2", s_axi_awready, s_axi_bid); else passed++;
        tick();
        s_axi_awvalid = 0; s_axi_bready = 0;
        total++; if (dut.wr_cnt !== 2'd1 || s_axi_awready !== 1'b1)
            $display("FAIL wl_simul: got cnt %0d awready %b want 1 1", dut.wr_cnt, s_axi_awready); else passed++;
        total++; if (m_axi_awvalid !== 1'b1 || m_axi_awid !== 4'd3)
            $display("FAIL wl_aw3_out: got v%b id %0d want v1 id 3", m_axi_awvalid, m_axi_awid); else passed++;
        m_axi_bvalid = 1; m_axi_bid = 3;
        tick();
        m_axi_bvalid = 0; s_axi_bready = 1;
        tick();
        s_axi_bready = 0;
        total++; if (dut.wr_cnt !== '0) $display("FAIL wl_drain: got cnt %0d want 0", dut.wr_cnt); else passed++;
    endtask

    task automatic test_read_limiter();
        m_axi_arready = 1; s_axi_rready = 1;
        s_axi_arvalid = 1; s_axi_arid = 6;
        total++; if (s_axi_arready !== 1'b1) $display("FAIL rl_ar1_ready: got %b want 1", s_axi_arready); else passed++;
        tick();
        s_axi_arid = 7;
        total++; if (s_axi_arready !== 1'b0) $display("FAIL rl_stall: got %b want 0", s_axi_arready); else passed++;
        m_axi_rvalid = 1; m_axi_rid = 6; m_axi_rlast = 1; m_axi_rdata = 32'h66;
        tick();
        m_axi_rvalid = 0;
        total++; if (s_axi_rvalid !== 1'b1 || s_axi_arready !== 1'b0)
            $display("FAIL rl_r_out: got rvalid %b arready %b want 1 0", s_axi_rvalid, s_axi_arready); else passed++;
        tick();
        total++; if (s_axi_arready !== 1'b1) $display("FAIL rl_restore: got %b want 1", s_axi_arready); else passed++;
        tick();
        s_axi_arvalid = 0;
        total++; if (s_axi_arready !== 1'b0 || dut.rd_cnt !== 1'd1 || m_axi_arid !== 4'd7)
            $display("FAIL rl_ar2: got arready %b cnt %0d m_id %0d want 0 1 7", s_axi_arready, dut.rd_cnt, m_axi_arid); else passed++;
        m_axi_rvalid = 1; m_axi_rid = 7; m_axi_rlast = 1;
        tick();
        m_axi_rvalid = 0;
        tick();
        total++; if (s_axi_arready !== 1'b1) $display("FAIL rl_drain: got %b want 1", s_axi_arready); else passed++;
    endtask

    task automatic test_user();
        m_axi_awready = 0;
        s_axi_awvalid = 1; s_axi_awid = 9; s_axi_awuser = 1;
        tick();
        s_axi_awvalid = 0; s_axi_awuser = 0;
        total++; if (m_axi_awvalid !== 1'b1 || m_axi_awuser !== EXP_USER)
            $display("FAIL user_aw: got v%b user %b want v1 user %b", m_axi_awvalid, m_axi_awuser, EXP_USER); else passed++;
    endtask

    initial begin
        {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
         s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser, s_axi_awvalid} = '0;
        {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
         s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser, s_axi_arvalid} = '0;
        {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser, s_axi_wvalid, s_axi_bready, s_axi_rready} = '0;
        {m_axi_awready, m_axi_wready, m_axi_arready} = '0;
        {m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid} = '0;
        {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        tick();
        test_reset();
        test_streaming();
        test_back_pressure();
        test_write_limiter();
        test_read_limiter();
        test_user();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
